// File: rtl/handshake_pkg.sv
// rtl/handshake_pkg.sv - shared types and constants for the handshake transmitter
package handshake_pkg;

  // Transmit FSM states; values are fixed so they read the same in waveforms everywhere
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } tx_state_e;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 4;
  localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with combinational head and occupancy count
module sync_fifo
  import handshake_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // The caller only pushes when not full and only pops when not empty,
  // so no overflow/underflow guarding is repeated here.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rdata = mem[rd_ptr];

  // Storage write; contents need no reset because pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally modulo DEPTH (power of two); level tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/handshake_tx_ctrl.sv
// rtl/handshake_tx_ctrl.sv - source-domain transmitter feeding the handshake synchronizer
module handshake_tx_ctrl
  import handshake_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic                   sready,
  output logic [WIDTH-1:0]       din,
  input  logic                   sidle,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic [XFER_CNT_W-1:0]  xfer_cnt
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  tx_state_e        state;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;

  // Full blocks pushes even when a pop happens the same cycle; keeps in_ready
  // a pure function of the registered level.
  assign in_ready = (level != FULL_LEVEL);
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (level != '0);

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (head),
    .level (level)
  );

  // Transmit FSM with registered request, data, busy flag and completion counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sready   <= 1'b0;
      din      <= '0;
      busy     <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            din    <= head;
            sready <= 1'b1;
            busy   <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          sready <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          if (sidle) begin
            xfer_cnt <= xfer_cnt + 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          sready <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_tx_ctrl.sv
// tb/tb_handshake_tx_ctrl.sv - self-checking bench for handshake_tx_ctrl
module tb_handshake_tx_ctrl;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         sready;
  logic [W-1:0] din;
  logic         sidle;
  logic         busy;
  logic [2:0]   level;
  logic [15:0]  xfer_cnt;

  handshake_tx_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .sready   (sready),
    .din      (din),
    .sidle    (sidle),
    .busy     (busy),
    .level    (level),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: words waiting, whether a transfer is outstanding,
  // whether the request pulse is showing this cycle, and the issue history.
  logic [W-1:0] q[$];
  logic [W-1:0] issued[$];
  bit           m_busy;
  bit           m_req;
  logic [W-1:0] m_din;
  logic [15:0]  m_cnt;

  task automatic model_reset();
    q.delete();
    m_busy = 1'b0;
    m_req  = 1'b0;
    m_din  = '0;
    m_cnt  = '0;
  endtask

  task automatic check_outs();
    chk("sready",   32'(sready),   32'(m_req));
    chk("din",      32'(din),      32'(m_din));
    chk("busy",     32'(busy),     32'(m_busy));
    chk("level",    32'(level),    32'(q.size()));
    chk("in_ready", 32'(in_ready), 32'(q.size() != D));
    chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
  endtask

  // Drive one cycle of inputs (called at negedge), advance the model across
  // the coming posedge, then check outputs at the following negedge.
  task automatic cycle(input bit v, input logic [W-1:0] d, input bit s);
    bit acc, issue, done;
    in_valid = v;
    in_data  = d;
    sidle    = s;
    acc   = v && (q.size() != D);
    issue = !m_busy && (q.size() != 0);
    done  = m_busy && !m_req && s;
    m_req = issue;
    if (issue) begin
      m_din  = q.pop_front();
      issued.push_back(m_din);
      m_busy = 1'b1;
    end
    if (done) begin
      m_busy = 1'b0;
      m_cnt  = m_cnt + 16'd1;
    end
    if (acc) q.push_back(d);
    @(posedge clk);
    @(negedge clk);
    check_outs();
  endtask

  task automatic wait_waiting();
    int n = 0;
    while (!(m_busy && !m_req) && n < 20) begin
      cycle(1'b0, '0, 1'b0);
      n++;
    end
    chk("wait_bound", 32'(n < 20), 32'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    sidle    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outs();
    rst_n = 1'b1;
    @(negedge clk);
    check_outs();

    // Single word: two-cycle issue latency, one-cycle request pulse
    issued.delete();
    cycle(1'b1, 8'hA5, 1'b0);
    chk("lat1_sready", 32'(sready), 32'd0);
    cycle(1'b0, '0, 1'b0);
    chk("lat2_sready", 32'(sready), 32'd1);
    chk("lat2_din", 32'(din), 32'hA5);
    cycle(1'b0, '0, 1'b0);
    chk("pulse_width", 32'(sready), 32'd0);
    repeat (4) cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1);
    chk("single_busy", 32'(busy), 32'd0);
    chk("single_cnt", 32'(xfer_cnt), 32'd1);

    // Backpressure: five words, then a refused sixth, then drain in order
    issued.delete();
    for (int i = 1; i <= 5; i++) cycle(1'b1, W'(i), 1'b0);
    chk("bp_level", 32'(level), 32'd4);
    chk("bp_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 8'h06, 1'b0);
    chk("bp_refused_level", 32'(level), 32'd4);
    for (int k = 0; k < 5; k++) begin
      wait_waiting();
      cycle(1'b0, '0, 1'b1);
    end
    chk("bp_issued_n", 32'(issued.size()), 32'd5);
    for (int i = 0; i < issued.size(); i++) chk("bp_order", 32'(issued[i]), 32'(i + 1));
    chk("bp_cnt", 32'(xfer_cnt), 32'd6);

    // Spurious sidle in IDLE and in the REQ cycle are ignored
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    chk("spur_idle_cnt", 32'(xfer_cnt), 32'd6);
    cycle(1'b1, 8'h77, 1'b0);
    cycle(1'b0, '0, 1'b0);
    chk("spur_req", 32'(sready), 32'd1);
    cycle(1'b0, '0, 1'b1);
    chk("spur_req_busy", 32'(busy), 32'd1);
    repeat (3) cycle(1'b0, '0, 1'b0);
    chk("spur_wait_busy", 32'(busy), 32'd1);
    cycle(1'b0, '0, 1'b1);
    chk("spur_cnt", 32'(xfer_cnt), 32'd7);

    // sidle held high for five cycles in WAIT with an empty FIFO
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    repeat (5) cycle(1'b0, '0, 1'b1);
    chk("held_cnt", 32'(xfer_cnt), 32'd8);
    chk("held_busy", 32'(busy), 32'd0);

    // Simultaneous push and pop keep level and order
    issued.delete();
    cycle(1'b1, 8'h31, 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 8'h32, 1'b0);
    cycle(1'b1, 8'h33, 1'b0);
    chk("simul_pre_level", 32'(level), 32'd2);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 8'h34, 1'b0);
    chk("simul_level", 32'(level), 32'd2);
    chk("simul_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 3; k++) begin
      wait_waiting();
      cycle(1'b0, '0, 1'b1);
    end
    chk("simul_n", 32'(issued.size()), 32'd4);
    for (int i = 0; i < issued.size(); i++) chk("simul_order", 32'(issued[i]), 32'(8'h31 + i));
    chk("simul_cnt", 32'(xfer_cnt), 32'd12);

    // Asynchronous reset mid-WAIT with three words queued
    cycle(1'b1, 8'h41, 1'b0);
    cycle(1'b1, 8'h42, 1'b0);
    cycle(1'b1, 8'h43, 1'b0);
    cycle(1'b1, 8'h44, 1'b0);
    in_valid = 1'b0;
    chk("rst_pre_level", 32'(level), 32'd3);
    chk("rst_pre_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sready", 32'(sready), 32'd0);
    chk("rst_din", 32'(din), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(xfer_cnt), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outs();
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b0, '0, 1'b0);
    chk("post_rst_sready", 32'(sready), 32'd1);
    chk("post_rst_din", 32'(din), 32'h3C);
    wait_waiting();
    cycle(1'b0, '0, 1'b1);
    chk("post_rst_cnt", 32'(xfer_cnt), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      cycle(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
